divide_seq: RTL and testbench
=============================

# divide_seq

Parametrised sequential restoring divider: successor to the fixed divide-by-ten block used by the display path. Divides an N-bit unsigned dividend by a runtime M-bit unsigned divisor, producing one quotient bit per clock with fixed latency independent of operand values. Adds a start/busy/done handshake, divide-by-zero detection and a synchronous datapath with asynchronous reset. Feeds the BCD digit extraction for the seven-segment display and any other decimal formatting.

## Interface
- N, 14, dividend and quotient width (N >= 2)
- M, 4, divisor and remainder width (1 <= M <= N)

- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request; sampled on rising edge, accepted only when busy=0
- dividend  in  N  unsigned dividend, captured when start is accepted
- divisor  in  M  unsigned divisor, captured when start is accepted
- busy  out  1  high while a division is in progress
- done  out  1  single-cycle pulse, result valid
- quotient  out  N  result quotient, held until next done
- remainder  out  M  result remainder, held until next done
- div_by_zero  out  1  set with done when captured divisor was 0; held until next done

## Operation
- FSM: IDLE, CALC. Reset state IDLE.
- IDLE: start=1 at edge captures dividend into shift register Q, divisor into D, clears partial remainder R (M+1 bits), loads bit counter with N. If divisor=0: stay IDLE, issue done with quotient={N{1}}, remainder=0, div_by_zero=1. Else go CALC, busy=1.
- CALC, per edge: T = {R[M-1:0], Q[N-1]}; Q <= {Q[N-2:0], T>=D}; R <= (T>=D) ? T-D : T; counter decrements. Compare/subtract is M+1 bits wide; no truncation.
- On edge processing the last bit (counter 1->0): publish quotient/remainder from working registers (final values), done=1, div_by_zero=0, busy=0, return to IDLE.
- Outputs quotient, remainder, div_by_zero change only on the edge that asserts done; working registers are internal.
- start while busy=1: ignored, no queuing, captured operands unaffected.
- Input changes on dividend/divisor after acceptance have no effect.

## Timing
- Reset (rst_n=0, asynchronous): busy=0, done=0, quotient=0, remainder=0, div_by_zero=0, FSM IDLE, counter 0. Takes effect without clock.
- Start accepted at edge E0. Nonzero divisor: busy=1 after E0; N iteration edges E1..EN; done=1 and busy=0 after EN; done=0 after EN+1. Latency N cycles.
- Divide-by-zero: done=1, div_by_zero=1 after E0 itself; busy never asserts. Latency 1 cycle.
- Back-to-back: during the done cycle FSM is IDLE, so start=1 at EN+1 is accepted; throughput one result per N+1 cycles minimum.
- done is exactly one cycle wide; never asserted twice per accepted start.
- Reset mid-CALC: operation aborted, no done pulse, outputs return to reset values.
- Reset release: first edge with rst_n=1 may accept start.

## Test plan
- N=14,M=4: dividend=1234, divisor=10, start one cycle -> busy high 14 cycles, done pulse after 14th iteration edge, quotient=123, remainder=4, div_by_zero=0.
- dividend=16383, divisor=15 -> quotient=1092, remainder=3; dividend=5, divisor=10 -> quotient=0, remainder=5; dividend=0, divisor=1 -> quotient=0, remainder=0.
- divisor=0, dividend=777 -> done one cycle after start, busy never high, quotient=16383, remainder=0, div_by_zero=1; next valid division clears div_by_zero.
- start 1234/10, reassert start with 99/9 on cycle 5 -> second request ignored, result 123 r4 only, single done.
- start 1234/10, pull rst_n low mid-CALC between edges -> all outputs 0 immediately, no done; after release 99/9 -> quotient=11, remainder=0.
- start held high continuously with 1000/7 -> done every 15 cycles, quotient=142, remainder=6 each time; also randomised sweep vs reference model for N=8,M=8 and N=14,M=4.

Source files
------------

// File: rtl/divide_seq.sv
// divide_seq - sequential restoring divider, one quotient bit per clock.
//
// Divides an N-bit unsigned dividend by a runtime M-bit unsigned divisor.
// The latency is fixed: N cycles for a nonzero divisor and 1 cycle for a
// zero divisor. It replaces the fixed divide-by-ten block and feeds BCD digit
// extraction for the seven-segment display.
//
// Parameters:
//   N  dividend / quotient width (N >= 2)
//   M  divisor / remainder width (1 <= M <= N)
//
// Ports:
//   clk          system clock, all state changes on the rising edge
//   rst_n        asynchronous active-low reset
//   start        request; accepted on a rising edge only while busy=0
//   dividend     unsigned dividend, captured when start is accepted
//   divisor      unsigned divisor, captured when start is accepted
//   busy         high while a division is iterating
//   done         single-cycle pulse; the result outputs are valid
//   quotient     result quotient, held until the next done
//   remainder    result remainder, held until the next done
//   div_by_zero  set with done when the captured divisor was zero

module divide_seq #(
  parameter int N = 14,
  parameter int M = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] dividend,
  input  logic [M-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] quotient,
  output logic [M-1:0] remainder,
  output logic         div_by_zero
);

  localparam int CW = $clog2(N + 1);

  typedef enum logic {IDLE, CALC} state_t;

  state_t         state;
  logic [N-1:0]   q_work;
  logic [M-1:0]   d_work;
  // The partial remainder is always below the divisor after each restoring
  // step. Its (M+1)-th bit is therefore always zero and is not stored. The
  // widened value reappears in the M+1 bit trial term below.
  logic [M-1:0]   r_work;
  logic [CW-1:0]  bit_cnt;

  logic [M:0]     trial;
  logic           fits;
  logic [M-1:0]   r_next;
  logic [N-1:0]   q_next;

  // One restoring step. The compare is M+1 bits wide. When the divisor fits,
  // trial - divisor is below the divisor, so the M-bit difference is exact.
  always_comb begin
    trial  = {r_work, q_work[N-1]};
    fits   = (trial >= {1'b0, d_work});
    r_next = fits ? (trial[M-1:0] - d_work) : trial[M-1:0];
    q_next = {q_work[N-2:0], fits};
  end

  // Control FSM and datapath. done defaults low every cycle, so it can only
  // ever be a one-cycle pulse. The result registers are written only on the
  // edge that raises done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      q_work      <= '0;
      d_work      <= '0;
      r_work      <= '0;
      bit_cnt     <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            q_work  <= dividend;
            d_work  <= divisor;
            r_work  <= '0;
            bit_cnt <= CW'(N);
            // A zero divisor is answered at once with the saturated quotient.
            if (divisor == '0) begin
              done        <= 1'b1;
              quotient    <= '1;
              remainder   <= '0;
              div_by_zero <= 1'b1;
            end else begin
              busy  <= 1'b1;
              state <= CALC;
            end
          end
        end
        CALC: begin
          q_work  <= q_next;
          r_work  <= r_next;
          bit_cnt <= bit_cnt - CW'(1);
          // The last iteration publishes the step's final values directly.
          if (bit_cnt == CW'(1)) begin
            quotient    <= q_next;
            remainder   <= r_next;
            div_by_zero <= 1'b0;
            done        <= 1'b1;
            busy        <= 1'b0;
            state       <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_divide_seq.sv
// tb_divide_seq - scoreboard testbench for divide_seq.
//
// Each accepted request pushes a result computed with plain integer division
// into a queue. Independent monitors pop that queue and compare whenever a
// DUT raises done. Two instances are exercised: N=14/M=4 and N=8/M=8.

module tb_divide_seq;

  localparam int N  = 14;
  localparam int M  = 4;
  localparam int N8 = 8;
  localparam int M8 = 8;

  typedef struct {
    int unsigned q;
    int unsigned r;
    int unsigned dbz;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          start = 1'b0;
  logic [N-1:0]  dividend = '0;
  logic [M-1:0]  divisor = '0;
  logic          busy;
  logic          done;
  logic [N-1:0]  quotient;
  logic [M-1:0]  remainder;
  logic          div_by_zero;

  logic          start8 = 1'b0;
  logic [N8-1:0] dividend8 = '0;
  logic [M8-1:0] divisor8 = '0;
  logic          busy8;
  logic          done8;
  logic [N8-1:0] quotient8;
  logic [M8-1:0] remainder8;
  logic          div_by_zero8;

  exp_t expQ[$];
  exp_t exp8Q[$];
  int   checks = 0;
  int   errors = 0;

  divide_seq #(.N(N), .M(M)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .dividend(dividend),
    .divisor(divisor), .busy(busy), .done(done), .quotient(quotient),
    .remainder(remainder), .div_by_zero(div_by_zero)
  );

  divide_seq #(.N(N8), .M(M8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .dividend(dividend8),
    .divisor(divisor8), .busy(busy8), .done(done8), .quotient(quotient8),
    .remainder(remainder8), .div_by_zero(div_by_zero8)
  );

  always #5 clk = ~clk;

  // Reference result from plain integer arithmetic.
  function automatic exp_t refModel(input int unsigned dd, input int unsigned ds, input int n);
    exp_t e;
    if (ds == 0) begin
      e.q   = (32'd1 << n) - 32'd1;
      e.r   = 0;
      e.dbz = 1;
    end else begin
      e.q   = dd / ds;
      e.r   = dd % ds;
      e.dbz = 0;
    end
    return e;
  endfunction

  task automatic checkOutput(input string name, input int unsigned actual, input int unsigned expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
    end
  endtask

  // Monitor for the 14/4 instance.
  always @(negedge clk) begin
    exp_t e;
    if (done) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpected_done", 32'(done), 0);
      end else begin
        e = expQ.pop_front();
        checkOutput("quotient", 32'(quotient), e.q);
        checkOutput("remainder", 32'(remainder), e.r);
        checkOutput("div_by_zero", 32'(div_by_zero), e.dbz);
      end
    end
  end

  // Monitor for the 8/8 instance.
  always @(negedge clk) begin
    exp_t e;
    if (done8) begin
      if (exp8Q.size() == 0) begin
        checkOutput("unexpected_done8", 32'(done8), 0);
      end else begin
        e = exp8Q.pop_front();
        checkOutput("quotient8", 32'(quotient8), e.q);
        checkOutput("remainder8", 32'(remainder8), e.r);
        checkOutput("div_by_zero8", 32'(div_by_zero8), e.dbz);
      end
    end
  end

  // One request on the 14/4 instance. It checks handshake timing and that
  // the result holds after done.
  task automatic applyStimulus(input logic [N-1:0] dd, input logic [M-1:0] ds);
    exp_t e;
    int   k;
    @(negedge clk);
    start    = 1'b1;
    dividend = dd;
    divisor  = ds;
    e = refModel(32'(dd), 32'(ds), N);
    expQ.push_back(e);
    @(negedge clk);
    start    = 1'b0;
    dividend = N'($urandom);
    divisor  = M'($urandom);
    k = 0;
    if (ds != 0) begin
      checkOutput("busy_after_accept", 32'(busy), 1);
      while (!done && k < N + 4) begin
        @(negedge clk);
        k++;
      end
    end else begin
      checkOutput("dbz_busy", 32'(busy), 0);
    end
    checkOutput("done_seen", 32'(done), 1);
    checkOutput("done_latency", 32'(k), (ds == 0) ? 0 : N);
    checkOutput("busy_with_done", 32'(busy), 0);
    @(negedge clk);
    checkOutput("done_width", 32'(done), 0);
    checkOutput("idle_after_done", 32'(busy), 0);
    checkOutput("quotient_held", 32'(quotient), e.q);
    checkOutput("remainder_held", 32'(remainder), e.r);
  endtask

  // One request on the 8/8 instance.
  task automatic applyStimulus8(input logic [N8-1:0] dd, input logic [M8-1:0] ds);
    int k;
    @(negedge clk);
    start8    = 1'b1;
    dividend8 = dd;
    divisor8  = ds;
    exp8Q.push_back(refModel(32'(dd), 32'(ds), N8));
    @(negedge clk);
    start8    = 1'b0;
    dividend8 = N8'($urandom);
    divisor8  = M8'($urandom);
    k = 0;
    while (!done8 && k < N8 + 4) begin
      @(negedge clk);
      k++;
    end
    checkOutput("done8_seen", 32'(done8), 1);
    checkOutput("done8_latency", 32'(k), (ds == 0) ? 0 : N8);
    @(negedge clk);
  endtask

  initial begin
    int doneCount;
    int k;
    int lastDone;

    // Asynchronous reset, asserted and checked before any clock edge.
    #1 rst_n = 1'b0;
    #2;
    checkOutput("reset_busy", 32'(busy), 0);
    checkOutput("reset_done", 32'(done), 0);
    checkOutput("reset_quotient", 32'(quotient), 0);
    checkOutput("reset_remainder", 32'(remainder), 0);
    checkOutput("reset_dbz", 32'(div_by_zero), 0);
    checkOutput("reset_busy8", 32'(busy8), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed cases, including a zero divisor followed by a valid division.
    applyStimulus(14'd1234, 4'd10);
    applyStimulus(14'd16383, 4'd15);
    applyStimulus(14'd5, 4'd10);
    applyStimulus(14'd0, 4'd1);
    applyStimulus(14'd777, 4'd0);
    applyStimulus(14'd99, 4'd9);
    applyStimulus(14'd16383, 4'd1);
    applyStimulus(14'd0, 4'd0);
    applyStimulus(14'd13, 4'd13);

    // A second start while busy must be ignored.
    @(negedge clk);
    start    = 1'b1;
    dividend = 14'd1234;
    divisor  = 4'd10;
    expQ.push_back(refModel(1234, 10, N));
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    start    = 1'b1;
    dividend = 14'd99;
    divisor  = 4'd9;
    @(negedge clk);
    start = 1'b0;
    doneCount = 0;
    for (int i = 0; i < N + 8; i++) begin
      @(negedge clk);
      if (done) doneCount++;
    end
    checkOutput("ignored_start_done_count", 32'(doneCount), 1);

    // Start held high: back-to-back results every N+1 cycles.
    @(negedge clk);
    start    = 1'b1;
    dividend = 14'd1000;
    divisor  = 4'd7;
    repeat (3) expQ.push_back(refModel(1000, 7, N));
    doneCount = 0;
    k = 0;
    lastDone = 0;
    while (doneCount < 3 && k < 3 * (N + 1) + 6) begin
      @(negedge clk);
      k++;
      if (done) begin
        doneCount++;
        checkOutput("stream_interval", 32'(k - lastDone), N + 1);
        lastDone = k;
      end
    end
    start = 1'b0;
    checkOutput("stream_count", 32'(doneCount), 3);
    repeat (N + 3) @(negedge clk);

    // Reset in the middle of an iteration aborts it without a done pulse.
    @(negedge clk);
    start    = 1'b1;
    dividend = 14'd1234;
    divisor  = 4'd10;
    expQ.push_back(refModel(1234, 10, N));
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    expQ.delete();
    #1;
    checkOutput("abort_busy", 32'(busy), 0);
    checkOutput("abort_done", 32'(done), 0);
    checkOutput("abort_quotient", 32'(quotient), 0);
    checkOutput("abort_remainder", 32'(remainder), 0);
    checkOutput("abort_dbz", 32'(div_by_zero), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (N + 2) @(negedge clk);
    applyStimulus(14'd99, 4'd9);

    // Randomised sweep against the reference model.
    repeat (30) applyStimulus(N'($urandom), M'($urandom_range(0, 15)));

    applyStimulus8(8'd255, 8'd1);
    applyStimulus8(8'd255, 8'd255);
    applyStimulus8(8'd0, 8'd0);
    applyStimulus8(8'd7, 8'd200);
    repeat (30) applyStimulus8(N8'($urandom), M8'($urandom_range(0, 255)));

    repeat (3) @(negedge clk);
    checkOutput("queue_drained", 32'(expQ.size()), 0);
    checkOutput("queue8_drained", 32'(exp8Q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Stop a hung run so that it does not simulate forever.
  initial begin
    #400000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
